// File: rtl/fp_comparator_pipe_if.sv
// rtl/fp_comparator_pipe_if.sv - operand/result handshake bundle for fp_comparator_pipe
// master = producer/consumer side, slave = comparator side.
interface fp_comparator_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_A;
  logic [W-1:0]     in_B;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_code;
  logic [CNT_W-1:0] nan_cnt;

  modport master (
    output in_valid, in_A, in_B, in_mode, out_ready,
    input  in_ready, out_valid, out_code, nan_cnt
  );

  modport slave (
    input  in_valid, in_A, in_B, in_mode, out_ready,
    output in_ready, out_valid, out_code, nan_cnt
  );
endinterface

// File: rtl/fp_comparator_pipe.sv
// rtl/fp_comparator_pipe.sv - two-stage IEEE-style / raw unsigned comparator with NaN counter
// S1 captures operands plus classification, S2 holds the 2-bit result code.
module fp_comparator_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  fp_comparator_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] CODE_EQ  = 2'b00;
  localparam logic [1:0] CODE_LT  = 2'b01;
  localparam logic [1:0] CODE_GT  = 2'b10;
  localparam logic [1:0] CODE_UNO = 2'b11;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;
  logic             s1_mode_q;
  logic             s1_a_nan_q;
  logic             s1_b_nan_q;
  logic             s1_a_zero_q;
  logic             s1_b_zero_q;
  logic             s2_valid_q;
  logic [1:0]       code_q;
  logic [CNT_W-1:0] nan_cnt_q;

  logic             s1_adv;
  logic             s2_adv;
  logic             a_nan_d;
  logic             b_nan_d;
  logic             a_zero_d;
  logic             b_zero_d;
  logic [1:0]       code_d;
  logic [CNT_W-1:0] nan_cnt_d;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  assign bus.out_valid = s2_valid_q;
  assign bus.out_code  = code_q;
  assign bus.nan_cnt   = nan_cnt_q;

  // Classification of the incoming operands, registered alongside them in S1.
  always_comb begin
    a_nan_d  = (&bus.in_A[W-2:MAN_W]) && (|bus.in_A[MAN_W-1:0]);
    b_nan_d  = (&bus.in_B[W-2:MAN_W]) && (|bus.in_B[MAN_W-1:0]);
    a_zero_d = ~|bus.in_A[W-2:0];
    b_zero_d = ~|bus.in_B[W-2:0];
  end

  // Sign-magnitude ordering: same-sign operands compare by {exp,man}, reversed when negative.
  always_comb begin
    code_d = CODE_EQ;
    if (s1_mode_q) begin
      if (s1_a_q == s1_b_q)     code_d = CODE_EQ;
      else if (s1_a_q < s1_b_q) code_d = CODE_LT;
      else                      code_d = CODE_GT;
    end else if (s1_a_nan_q || s1_b_nan_q) begin
      code_d = CODE_UNO;
    end else if (s1_a_zero_q && s1_b_zero_q) begin
      code_d = CODE_EQ;
    end else if (s1_a_q[W-1] != s1_b_q[W-1]) begin
      code_d = s1_a_q[W-1] ? CODE_LT : CODE_GT;
    end else if (s1_a_q[W-2:0] == s1_b_q[W-2:0]) begin
      code_d = CODE_EQ;
    end else if ((s1_a_q[W-2:0] < s1_b_q[W-2:0]) ^ s1_a_q[W-1]) begin
      code_d = CODE_LT;
    end else begin
      code_d = CODE_GT;
    end
  end

  always_comb begin
    nan_cnt_d = nan_cnt_q;
    if (s2_valid_q && bus.out_ready && (code_q == CODE_UNO) && (nan_cnt_q != CNT_MAX))
      nan_cnt_d = nan_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= 1'b0;
      s1_a_nan_q  <= 1'b0;
      s1_b_nan_q  <= 1'b0;
      s1_a_zero_q <= 1'b0;
      s1_b_zero_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      code_q      <= CODE_EQ;
      nan_cnt_q   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a_q      <= bus.in_A;
          s1_b_q      <= bus.in_B;
          s1_mode_q   <= bus.in_mode;
          s1_a_nan_q  <= a_nan_d;
          s1_b_nan_q  <= b_nan_d;
          s1_a_zero_q <= a_zero_d;
          s1_b_zero_q <= b_zero_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q)
          code_q <= code_d;
      end
      nan_cnt_q <= nan_cnt_d;
    end
  end
endmodule

// File: tb/tb_fp_comparator_pipe.sv
// tb/tb_fp_comparator_pipe.sv - self-checking bench for fp_comparator_pipe
// Directed and randomized pairs scored against a value-level reference model.
module tb_fp_comparator_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_comparator_pipe_if ifa ();
  fp_comparator_pipe_if #(.CNT_W(2)) ifb ();

  fp_comparator_pipe dut (.clk(clk), .rst(rst), .bus(ifa));
  fp_comparator_pipe #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int failures = 0;
  logic [1:0] expq[$];
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Real-number ordering: value = +/- magnitude, NaN unordered, -0 == +0.
  function automatic logic [1:0] ref_code(input logic [31:0] a, input logic [31:0] b, input logic mode);
    longint ka, kb;
    bit na, nb;
    if (mode) return (a == b) ? 2'd0 : ((a < b) ? 2'd1 : 2'd2);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (na || nb) return 2'd3;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    if (ka == kb) return 2'd0;
    return (ka < kb) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      3: return {s, 8'h00, 23'($urandom)};
      4: return other;
      5: return other ^ 32'h1;
      6: return {~other[31], other[30:0]};
      default: return $urandom;
    endcase
  endfunction

  // Inputs are driven at the negedge; handshakes are scored just before the next posedge.
  task automatic tick(output bit acc);
    bit ov, ordy;
    logic [1:0] oc;
    logic [1:0] e;
    #1;
    acc = ifa.in_valid && ifa.in_ready;
    if (acc) expq.push_back(ref_code(ifa.in_A, ifa.in_B, ifa.in_mode));
    ov = ifa.out_valid;
    ordy = ifa.out_ready;
    oc = ifa.out_code;
    if (ov && ordy) begin
      if (expq.size() == 0) begin
        chk("spurious_out", 32'(ov), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("code", 32'(oc), 32'(e));
        if (e == 2'd3 && model_cnt < 65535) model_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("nan_cnt", 32'(ifa.nan_cnt), 32'(model_cnt));
    if (ov && !ordy) begin
      chk("hold_valid", 32'(ifa.out_valid), 32'd1);
      chk("hold_code", 32'(ifa.out_code), 32'(oc));
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic mode);
    bit acc;
    acc = 0;
    ifa.in_valid = 1'b1;
    ifa.in_A = a;
    ifa.in_B = b;
    ifa.in_mode = mode;
    for (int n = 0; n < 20 && !acc; n++) tick(acc);
    chk("send_accept", 32'(acc), 32'd1);
    ifa.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    for (int n = 0; n < 20 && expq.size() != 0; n++) tick(acc);
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int sent;
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic [31:0] a, b;

    ifa.in_valid = 1'b1;
    ifa.in_A = 32'h3F800000;
    ifa.in_B = 32'h40000000;
    ifa.in_mode = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0;
    ifb.in_A = '0;
    ifb.in_B = '0;
    ifb.in_mode = 1'b0;
    ifb.out_ready = 1'b1;

    // Reset held across edges with in_valid high must not accept anything.
    #1;
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_code", 32'(ifa.out_code), 32'd0);
    chk("rst_nan_cnt", 32'(ifa.nan_cnt), 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("post_rst_idle", 32'(ifa.out_valid), 32'd0);
    end

    // Latency: accepted at edge k, visible after edge k+1.
    ifa.in_valid = 1'b1;
    ifa.in_A = 32'h3F800000;
    ifa.in_B = 32'h40000000;
    ifa.in_mode = 1'b0;
    tick(acc);
    chk("lat_accept", 32'(acc), 32'd1);
    ifa.in_valid = 1'b0;
    chk("lat_k", 32'(ifa.out_valid), 32'd0);
    tick(acc);
    chk("lat_k1_valid", 32'(ifa.out_valid), 32'd1);
    chk("lat_k1_code", 32'(ifa.out_code), 32'd1);
    drain();

    send(32'h80000000, 32'h00000000, 1'b0);
    send(32'hC0000000, 32'hBF800000, 1'b0);
    send(32'h7F800000, 32'h7F7FFFFF, 1'b0);
    drain();

    send(32'h7FC00000, 32'h12345678, 1'b0);
    drain();
    chk("nan_cnt_one", 32'(ifa.nan_cnt), 32'd1);
    send(32'h7FC00000, 32'h00000000, 1'b1);
    drain();
    chk("raw_nan_cnt", 32'(ifa.nan_cnt), 32'd1);

    // Four back-to-back pairs against a 5-cycle downstream stall.
    pa = '{32'h3F800000, 32'h40000000, 32'h80000000, 32'h7FC00000};
    pb = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000};
    sent = 0;
    ifa.out_ready = 1'b0;
    ifa.in_mode = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (sent == 2) chk("stall_in_ready", 32'(ifa.in_ready), 32'd0);
      ifa.in_valid = 1'b1;
      ifa.in_A = pa[sent];
      ifa.in_B = pb[sent];
      tick(acc);
      if (acc) sent++;
    end
    chk("stall_accepts", 32'(sent), 32'd2);
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ifa.in_valid = (sent < 4);
      ifa.in_A = pa[sent % 4];
      ifa.in_B = pb[sent % 4];
      chk("no_gap", 32'(ifa.out_valid), 32'd1);
      tick(acc);
      if (acc) sent++;
    end
    ifa.in_valid = 1'b0;
    chk("stall_all_sent", 32'(sent), 32'd4);
    chk("stall_order_done", 32'(expq.size()), 32'd0);

    // Asynchronous reset with two pairs in flight.
    ifa.out_ready = 1'b0;
    send(32'h7FC00000, 32'h0, 1'b0);
    send(32'h3F800000, 32'h0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("arst_nan_cnt", 32'(ifa.nan_cnt), 32'd0);
    chk("arst_in_ready", 32'(ifa.in_ready), 32'd1);
    rst = 1'b0;
    expq.delete();
    model_cnt = 0;
    @(negedge clk);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      chk("arst_no_result", 32'(ifa.out_valid), 32'd0);
    end

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      b = $urandom;
      a = rand_op(b);
      if ($urandom_range(0, 1) == 1) b = rand_op(a);
      ifa.in_valid = ($urandom_range(0, 9) < 7);
      ifa.in_A = a;
      ifa.in_B = b;
      ifa.in_mode = ($urandom_range(0, 3) == 0);
      ifa.out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    drain();

    // Saturating counter on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      bit seen;
      seen = 0;
      ifb.in_valid = 1'b1;
      ifb.in_A = 32'h7FC00001;
      ifb.in_B = $urandom;
      ifb.in_mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ifb.in_valid = 1'b0;
      for (int n = 0; n < 6 && !seen; n++) begin
        if (ifb.out_valid) seen = 1;
        @(posedge clk);
        @(negedge clk);
      end
      chk("sat_delivered", 32'(seen), 32'd1);
      chk("sat_cnt", 32'(ifb.nan_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_comparator_pipe.md
FP_COMPARATOR_PIPE -- requirements
Module: fp_comparator_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width in bits.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width in bits; operand width W = 1+EXP_W+MAN_W, with the sign in bit W-1.
REQ-003 SHALL have parameter CNT_W, default 16, width of the unordered-event counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operand pair present.
REQ-007 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 SHALL have port in_A  input  W  operand A.
REQ-009 SHALL have port in_B  input  W  operand B.
REQ-010 SHALL have port in_mode  input  1  compare mode: 0 = floating-point, 1 = raw unsigned bit pattern.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_code  output  2  result: 00 EQUAL, 01 A<B, 10 A>B, 11 unordered.
REQ-014 SHALL have port nan_cnt  output  CNT_W  count of unordered results delivered.

Function
REQ-015 SHALL take a transfer in when in_valid && in_ready at a rising edge, and a transfer out when out_valid && out_ready.
REQ-016 SHALL be a 2-stage pipeline:
- S1 registers the operands, the mode, and the classification (NaN, zero, sign).
- S2 registers out_code.
REQ-017 SHALL use this advance rule:
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv, combinational, with no dependency on in_valid.
REQ-018 SHALL have a latency of 2 cycles: a pair accepted at edge k gives out_valid=1 after edge k+1 when there is no stall.
REQ-019 SHALL sustain a throughput of 1 pair per cycle while out_ready=1.
REQ-020 SHALL hold out_code and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL neither drop nor duplicate pairs, and SHALL deliver results in acceptance order.
REQ-022 SHALL, in mode 1, compare in_A and in_B as unsigned integers: 00 if A==B, 01 if A<B, 10 if A>B; 11 is never produced.
REQ-023 SHALL, in mode 0, treat an operand as NaN when the exponent is all ones and the mantissa is nonzero; if either operand is NaN, the code is 11.
REQ-024 SHALL, in mode 0, treat +0 and -0 as equal (code 00), regardless of sign.
REQ-025 SHALL, in mode 0 with different signs and not both zero, give 01 if A is negative, else 10.
REQ-026 SHALL, in mode 0 with both operands positive, compare the magnitude bits {exp,man} as unsigned.
REQ-027 SHALL, in mode 0 with both operands negative, use the inverse magnitude order.
REQ-028 SHALL order infinities and subnormals by their bit patterns under REQ-026/REQ-027 with no special casing, so that +inf > +max and -inf < -max.
REQ-029 SHALL increment nan_cnt by 1 on each out-transfer with out_code=11.
REQ-030 SHALL saturate nan_cnt at 2^CNT_W-1 (no wrap).
REQ-031 SHALL not change nan_cnt on a stalled, unaccepted result.
REQ-032 SHALL treat in_A, in_B and in_mode as don't-care when !(in_valid && in_ready).

Reset
REQ-033 SHALL, while rst=1, immediately force s1_valid=0, s2_valid=0, out_valid=0, out_code=00 and nan_cnt=0, without waiting for a clk edge.
REQ-034 SHALL drive in_ready=1 while rst=1 is held, but SHALL accept no transfer in any cycle where rst=1 at the edge.
REQ-035 SHALL discard all in-flight pairs when rst asserts mid-operation; none is delivered after reset release.

Verification
REQ-036 SHALL cover: mode 0, EXP_W=8/MAN_W=23, A=0x3F800000 (1.0), B=0x40000000 (2.0) -> out_code=01 two cycles after acceptance.
REQ-037 SHALL cover: mode 0, A=0x80000000, B=0x00000000 -> 00; A=0xC0000000, B=0xBF800000 -> 01; A=0x7F800000, B=0x7F7FFFFF -> 10.
REQ-038 SHALL cover: mode 0, A=0x7FC00000, B=any -> 11 with nan_cnt=1; the same pair in mode 1 -> 10 when B=0 and nan_cnt unchanged.
REQ-039 SHALL cover: 4 back-to-back pairs with out_ready held 0 for 5 cycles -> in_ready=0 after 2 accepts; on release, 4 results in order with no gaps at out_ready=1.
REQ-040 SHALL cover: rst pulse asynchronous to clk with 2 pairs in flight -> out_valid=0 and nan_cnt=0 immediately; no result appears after release.
REQ-041 SHALL cover: CNT_W=2, 5 NaN results -> nan_cnt sequence 1,2,3,3,3.
